stu_ctrl: RTL and testbench

STU_CTRL -- requirements
Module: stu_ctrl

---
 rtl/stu_pkg.sv | 36 +++
 rtl/stu_minmax.sv | 48 ++++
 rtl/stu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_stu_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stu_pkg.sv
// ============================================================================
// Module      : stu_pkg
// Description : Shared FSM encoding, result bit indices and width defaults
//               for the sensor self-test controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stu_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACQ    = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4
  } stu_state_e;

  localparam int SENS_BELOW  = 0;
  localparam int SENS_ABOVE  = 1;
  localparam int SENS_TMO    = 2;
  localparam int SENS_STUCK  = 3;
  localparam int SENS_RETRIG = 4;
  localparam int SENS_PASS   = 5;

  // A zero-length window would never complete, so it behaves as one sample.
  function automatic logic [7:0] eff_win(input logic [7:0] win);
    return (win == 8'd0) ? 8'd1 : win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stu_minmax.sv
// ============================================================================
// Module      : stu_minmax
// Description : Running min / max / sample-count tracker for one check window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stu_minmax #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] max_o,
  output logic [7:0]    cnt_o
);

  logic [DW-1:0] min_q;
  logic [DW-1:0] max_q;
  logic [7:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      min_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (vld_i) begin
      if (cnt_q == 8'd0) begin
        min_q <= data_i;
        max_q <= data_i;
      end else begin
        if (data_i < min_q) min_q <= data_i;
        if (data_i > max_q) max_q <= data_i;
      end
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/stu_ctrl.sv
// ============================================================================
// Module      : stu_ctrl
// Description : Sensor self-test controller: settle, acquire a window of AD
//               samples, evaluate range/stuck/timeout and publish a result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stu_ctrl
  import stu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_us,
  input  logic          ast,
  input  logic [DW-1:0] ad_data,
  input  logic          ad_vld,
  input  logic [TW-1:0] cfg_settle_us,
  input  logic [7:0]    cfg_win_len,
  input  logic [TW-1:0] cfg_timeout_us,
  input  logic [DW-1:0] cfg_thr_lo,
  input  logic [DW-1:0] cfg_thr_hi,
  output logic          chk_busy,
  output logic          chk_done,
  output logic [7:0]    stu_sensor
);

  stu_state_e    state_q, state_d;
  logic          ast_q, rst_dly_q;
  logic [TW-1:0] settle_q, settle_d, tmo_q, tmo_d, cnt_q, cnt_d;
  logic [7:0]    win_q, win_d;
  logic [DW-1:0] lo_q, lo_d, hi_q, hi_d;
  logic          below_q, below_d, above_q, above_d;
  logic          tflag_q, tflag_d, retrig_q, retrig_d;
  logic [7:0]    sensor_q, sensor_d;

  logic          w_edge, w_smp, w_win_done, w_tmo_hit, w_stuck;
  logic [TW-1:0] w_cnt_inc;
  logic [DW-1:0] w_min, w_max;
  logic [7:0]    w_mm_cnt;

  // The cycle right after reset release only primes ast_q, so a level that
  // was already high through reset is never mistaken for a rising edge.
  assign w_edge     = ast & ~ast_q & ~rst_dly_q;
  assign w_smp      = ad_vld && (state_q == ST_ACQ);
  assign w_cnt_inc  = cnt_q + TW'(1);
  assign w_win_done = w_smp && (({1'b0, w_mm_cnt} + 9'd1) >= {1'b0, eff_win(win_q)});
  assign w_tmo_hit  = pluse_us && (tmo_q != '0) && (w_cnt_inc == tmo_q);
  assign w_stuck    = (w_mm_cnt >= 8'd2) && (w_max == w_min);

  stu_minmax #(.DW(DW)) u_minmax (
    .clk    (clk_sys),
    .rst    (rst),
    .clr_i  (state_q == ST_IDLE),
    .vld_i  (w_smp),
    .data_i (ad_data),
    .min_o  (w_min),
    .max_o  (w_max),
    .cnt_o  (w_mm_cnt)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ast_q     <= 1'b0;
      rst_dly_q <= 1'b1;
      settle_q  <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      below_q   <= 1'b0;
      above_q   <= 1'b0;
      tflag_q   <= 1'b0;
      retrig_q  <= 1'b0;
      sensor_q  <= '0;
    end else begin
      state_q   <= state_d;
      ast_q     <= ast;
      rst_dly_q <= 1'b0;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      below_q   <= below_d;
      above_q   <= above_d;
      tflag_q   <= tflag_d;
      retrig_q  <= retrig_d;
      sensor_q  <= sensor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    below_d  = below_q;
    above_d  = above_q;
    tflag_d  = tflag_q;
    retrig_d = retrig_q;
    sensor_d = sensor_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        below_d  = 1'b0;
        above_d  = 1'b0;
        tflag_d  = 1'b0;
        retrig_d = 1'b0;
        if (w_edge) begin
          settle_d = cfg_settle_us;
          tmo_d    = cfg_timeout_us;
          win_d    = cfg_win_len;
          lo_d     = cfg_thr_lo;
          hi_d     = cfg_thr_hi;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_edge) retrig_d = 1'b1;
        if (settle_q == '0) begin
          cnt_d   = '0;
          state_d = ST_ACQ;
        end else if (pluse_us) begin
          if (w_cnt_inc == settle_q) begin
            cnt_d   = '0;
            state_d = ST_ACQ;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end
      end
      ST_ACQ: begin
        if (w_edge) retrig_d = 1'b1;
        if (pluse_us) cnt_d = w_cnt_inc;
        if (w_smp && (ad_data < lo_q)) below_d = 1'b1;
        if (w_smp && (ad_data > hi_q)) above_d = 1'b1;
        // A sample that completes the window wins over a coincident timeout.
        if (w_win_done) begin
          state_d = ST_EVAL;
        end else if (w_tmo_hit) begin
          tflag_d = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        sensor_d              = '0;
        sensor_d[SENS_BELOW]  = below_q;
        sensor_d[SENS_ABOVE]  = above_q;
        sensor_d[SENS_TMO]    = tflag_q;
        sensor_d[SENS_STUCK]  = w_stuck;
        sensor_d[SENS_RETRIG] = retrig_q | w_edge;
        sensor_d[SENS_PASS]   = ~(below_q | above_q | tflag_q | w_stuck);
        state_d               = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign chk_busy   = (state_q != ST_IDLE);
  assign chk_done   = (state_q == ST_DONE);
  assign stu_sensor = sensor_q;

endmodule

`default_nettype wire

// File: tb/tb_stu_ctrl.sv
// ============================================================================
// Module      : tb_stu_ctrl
// Description : Directed self-checking bench for stu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stu_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        pluse_us = 1'b0;
  logic        ast = 1'b0;
  logic        ad_vld = 1'b0;
  logic [15:0] ad_data = '0;
  logic [15:0] cfg_settle_us = '0;
  logic [7:0]  cfg_win_len = '0;
  logic [15:0] cfg_timeout_us = '0;
  logic [15:0] cfg_thr_lo = '0;
  logic [15:0] cfg_thr_hi = '0;
  logic        chk_busy;
  logic        chk_done;
  logic [7:0]  stu_sensor;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  stu_ctrl #(.DW(16), .TW(16)) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .pluse_us       (pluse_us),
    .ast            (ast),
    .ad_data        (ad_data),
    .ad_vld         (ad_vld),
    .cfg_settle_us  (cfg_settle_us),
    .cfg_win_len    (cfg_win_len),
    .cfg_timeout_us (cfg_timeout_us),
    .cfg_thr_lo     (cfg_thr_lo),
    .cfg_thr_hi     (cfg_thr_hi),
    .chk_busy       (chk_busy),
    .chk_done       (chk_done),
    .stu_sensor     (stu_sensor)
  );

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic config_run(input logic [15:0] settle, input logic [7:0] win,
                            input logic [15:0] tmo, input logic [15:0] lo,
                            input logic [15:0] hi);
    cfg_settle_us  = settle;
    cfg_win_len    = win;
    cfg_timeout_us = tmo;
    cfg_thr_lo     = lo;
    cfg_thr_hi     = hi;
  endtask

  task automatic start();
    ast = 1'b1;
    cyc();
    ast = 1'b0;
  endtask

  task automatic tick();
    pluse_us = 1'b1;
    cyc();
    pluse_us = 1'b0;
    cyc();
  endtask

  task automatic sample(input logic [15:0] v);
    ad_data = v;
    ad_vld  = 1'b1;
    cyc();
    ad_vld  = 1'b0;
  endtask

  // Called in the EVAL cycle (the cycle after the completing event).
  task automatic expect_done(input string tag, input logic [7:0] exp);
    check({tag, ".eval_no_done"}, {31'd0, chk_done}, 32'd0);
    cyc();
    check({tag, ".done"}, {31'd0, chk_done}, 32'd1);
    check({tag, ".sensor"}, {24'd0, stu_sensor}, {24'd0, exp});
    cyc();
    check({tag, ".done_single"}, {31'd0, chk_done}, 32'd0);
    check({tag, ".idle"}, {31'd0, chk_busy}, 32'd0);
    check({tag, ".sensor_hold"}, {24'd0, stu_sensor}, {24'd0, exp});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("reset.sensor", {24'd0, stu_sensor}, 32'h00);
    check("reset.busy", {31'd0, chk_busy}, 32'd0);
    check("reset.done", {31'd0, chk_done}, 32'd0);

    // Nominal pass; a sample offered during SETTLE must be ignored.
    config_run(16'd3, 8'd4, 16'd0, 16'd100, 16'd900);
    start();
    check("pass.busy", {31'd0, chk_busy}, 32'd1);
    sample(16'd5);
    tick(); tick(); tick();
    sample(16'd500); sample(16'd510); sample(16'd490); sample(16'd505);
    expect_done("pass", 8'h20);

    // Low and high violations; cfg changes mid-run must not take effect.
    start();
    cfg_win_len = 8'd2;
    cfg_thr_hi  = 16'd2000;
    tick(); tick(); tick();
    sample(16'd500); sample(16'd50); sample(16'd950); sample(16'd500);
    expect_done("range", 8'h03);
    config_run(16'd3, 8'd4, 16'd10, 16'd100, 16'd900);

    // Timeout with two distinct samples.
    start();
    tick(); tick(); tick();
    sample(16'd500); sample(16'd600);
    for (int i = 0; i < 9; i++) tick();
    check("tmo2.still_busy", {31'd0, chk_busy}, 32'd1);
    check("tmo2.no_done", {31'd0, chk_done}, 32'd0);
    pluse_us = 1'b1;
    cyc();
    pluse_us = 1'b0;
    expect_done("tmo2", 8'h04);

    // Timeout with zero samples.
    start();
    tick(); tick(); tick();
    for (int i = 0; i < 9; i++) tick();
    pluse_us = 1'b1;
    cyc();
    pluse_us = 1'b0;
    expect_done("tmo0", 8'h04);

    // Stuck sensor.
    config_run(16'd3, 8'd3, 16'd0, 16'd100, 16'd900);
    start();
    tick(); tick(); tick();
    sample(16'd700); sample(16'd700); sample(16'd700);
    expect_done("stuck", 8'h08);

    // Stuck plus a retrigger pulse mid-acquisition.
    start();
    tick(); tick(); tick();
    sample(16'd700);
    ast = 1'b1;
    cyc();
    ast = 1'b0;
    check("retrig.busy", {31'd0, chk_busy}, 32'd1);
    sample(16'd700); sample(16'd700);
    expect_done("retrig", 8'h18);
    cyc();
    check("retrig.no_second_done", {31'd0, chk_done}, 32'd0);

    // Window-completing sample coincides with the final timeout tick.
    config_run(16'd0, 8'd2, 16'd3, 16'd100, 16'd900);
    start();
    cyc();
    pluse_us = 1'b1; ad_vld = 1'b1; ad_data = 16'd300;
    cyc();
    pluse_us = 1'b0; ad_vld = 1'b0;
    cyc();
    tick();
    pluse_us = 1'b1; ad_vld = 1'b1; ad_data = 16'd400;
    cyc();
    pluse_us = 1'b0; ad_vld = 1'b0;
    expect_done("coinc", 8'h20);

    // win_len 0 acts as 1; an edge during DONE is ignored.
    config_run(16'd0, 8'd0, 16'd0, 16'd100, 16'd900);
    start();
    cyc();
    sample(16'd200);
    check("win0.eval", {31'd0, chk_done}, 32'd0);
    cyc();
    check("win0.done", {31'd0, chk_done}, 32'd1);
    check("win0.sensor", {24'd0, stu_sensor}, 32'h20);
    ast = 1'b1;
    cyc();
    check("done_edge.ignored", {31'd0, chk_busy}, 32'd0);
    cyc();
    check("done_edge.still_idle", {31'd0, chk_busy}, 32'd0);
    ast = 1'b0;
    cyc();

    // An edge in the IDLE cycle right after DONE starts a new run.
    start();
    cyc();
    sample(16'd200);
    cyc();
    check("idle_edge.done", {31'd0, chk_done}, 32'd1);
    cyc();
    ast = 1'b1;
    cyc();
    ast = 1'b0;
    check("idle_edge.started", {31'd0, chk_busy}, 32'd1);
    cyc();
    sample(16'd950);
    expect_done("idle_edge", 8'h02);

    // Reset mid-acquisition aborts without publishing.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    config_run(16'd3, 8'd4, 16'd0, 16'd100, 16'd900);
    start();
    tick(); tick(); tick();
    sample(16'd500); sample(16'd510);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort.busy", {31'd0, chk_busy}, 32'd0);
    check("abort.sensor", {24'd0, stu_sensor}, 32'h00);
    sample(16'd490); sample(16'd505);
    for (int i = 0; i < 4; i++) begin
      check("abort.no_done", {31'd0, chk_done}, 32'd0);
      cyc();
    end
    check("abort.sensor_kept", {24'd0, stu_sensor}, 32'h00);

    // ast held high through reset release must not start a run.
    ast = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_ast_high.idle", {31'd0, chk_busy}, 32'd0);
    ast = 1'b0;
    cyc();
    ast = 1'b1;
    cyc();
    ast = 1'b0;
    check("rst_ast_high.new_edge", {31'd0, chk_busy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
